// File: rtl/sr_lsu.sv
// Load/store unit: turns one byte/half/word request into byte-serial accesses
// on an 8-bit RAM port and returns a single-cycle, extended response.
module sr_lsu #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_sign,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, last_addr, cur_addr;
    logic [1:0]        size, cnt, cnt_last;
    logic              sign, we, err;
    logic [3:0][7:0]   wbytes, rbuf;
    logic [7:0]        last_wdata;
    logic              req_illegal;

    assign req_illegal = (req_size == 2'b11)
                      || (req_size == 2'b01 && req_addr[0])
                      || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                      || ((req_addr >> ADDR_W) != 32'd0);

    // Address arithmetic stays ADDR_W wide so it wraps around the byte space.
    assign cur_addr = base + ADDR_W'(cnt);
    assign cnt_last = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = req_illegal ? RESP : ACCESS;
            ACCESS:  if (cnt == cnt_last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err;
    assign mem_we    = (state == ACCESS) && we;
    assign mem_addr  = (state == ACCESS) ? cur_addr : last_addr;
    assign mem_wdata = mem_we ? wbytes[cnt] : last_wdata;

    always_comb begin
        rsp_rdata = 32'd0;
        if (state == RESP && !we && !err) begin
            unique case (size)
                2'b00:   rsp_rdata = {{24{sign & rbuf[0][7]}}, rbuf[0]};
                2'b01:   rsp_rdata = {{16{sign & rbuf[1][7]}}, rbuf[1], rbuf[0]};
                default: rsp_rdata = rbuf;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            size       <= 2'b00;
            sign       <= 1'b0;
            we         <= 1'b0;
            err        <= 1'b0;
            wbytes     <= '0;
            cnt        <= 2'd0;
            rbuf       <= '0;
            last_addr  <= '0;
            last_wdata <= 8'd0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        base   <= req_addr[ADDR_W-1:0];
                        size   <= req_size;
                        sign   <= req_sign;
                        we     <= req_we;
                        wbytes <= req_wdata;
                        err    <= req_illegal;
                        cnt    <= 2'd0;
                    end
                end
                ACCESS: begin
                    cnt       <= cnt + 2'd1;
                    last_addr <= cur_addr;
                    if (we) last_wdata <= wbytes[cnt];
                    else    rbuf[cnt]  <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: directed scenarios plus randomized traffic
// compared against a byte-array memory model of the load/store semantics.
module tb_sr_lsu;

    localparam int ADDR_W = 8;
    localparam int MSIZE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_sign;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata, mem_rdata;

    sr_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sign(req_sign), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT, and the bench's own expectation of its content.
    logic [7:0] tb_mem  [MSIZE];
    logic [7:0] ref_mem [MSIZE];
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent transaction.
    int         obs_lat;
    logic [31:0] obs_rdata;
    logic       obs_err, obs_busy_ok, obs_after;
    logic [7:0] obs_wa[$];
    logic [7:0] obs_wd[$];

    task automatic run_req(input logic we, input logic sign, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic done;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_sign = sign; req_size = size;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        obs_wa.delete(); obs_wd.delete();
        obs_lat = 0; obs_busy_ok = 1'b1; done = 1'b0;
        obs_rdata = 32'hx; obs_err = 1'bx;
        for (int k = 1; k <= 16 && !done; k++) begin
            @(negedge clk);
            if (req_ready) obs_busy_ok = 1'b0;
            if (mem_we) begin obs_wa.push_back(mem_addr); obs_wd.push_back(mem_wdata); end
            if (rsp_valid) begin
                obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err; done = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rsp_timeout: no rsp_valid within 16 cycles"); end
        @(negedge clk);
        obs_after = rsp_valid | rsp_err;
    endtask

    // Reference semantics: byte array, little-endian assembly, arithmetic extension.
    task automatic model(input logic we, input logic sign, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic exp_err, output logic [31:0] exp_rdata,
                         output int exp_lat, output int exp_nw);
        int n;
        longint unsigned v;
        n = 1 << size;
        exp_err = (size == 2'b11) || (addr % n != 0) || (addr >= MSIZE);
        exp_rdata = 32'd0;
        exp_lat = exp_err ? 1 : n + 1;
        exp_nw  = (!exp_err && we) ? n : 0;
        if (!exp_err && we)
            for (int i = 0; i < n; i++) ref_mem[(addr + i) % MSIZE] = wdata[8*i +: 8];
        if (!exp_err && !we) begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[(addr + i) % MSIZE]) << (8 * i);
            if (sign && n < 4 && v >= (64'd1 << (8 * n - 1))) v += 64'hFFFF_FFFF - ((64'd1 << (8 * n)) - 1);
            exp_rdata = v[31:0];
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags: got ready/valid/err/we=%b expected 1000",
                               {req_ready, rsp_valid, rsp_err, mem_we});
        end
        n_checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected zeros",
                               rsp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_word();
        logic e; logic [31:0] r; int l, nw;
        model(1'b1, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, e, r, l, nw);
        run_req(1'b1, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF);
        n_checks++;
        if (obs_wa.size() !== 4) begin
            n_fail++; $display("FAIL t1_store_count: got %0d writes expected 4", obs_wa.size());
        end else begin
            n_checks++;
            if ({obs_wa[0], obs_wa[1], obs_wa[2], obs_wa[3]} !== 32'h10111213 ||
                {obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]} !== 32'hEFBEADDE) begin
                n_fail++; $display("FAIL t1_store_bytes: got addr %h %h %h %h data %h %h %h %h expected 10..13 EF BE AD DE",
                                   obs_wa[0], obs_wa[1], obs_wa[2], obs_wa[3],
                                   obs_wd[0], obs_wd[1], obs_wd[2], obs_wd[3]);
            end
        end
        n_checks++;
        if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL t1_store_rsp: got rdata=%h err=%b expected 0/0", obs_rdata, obs_err);
        end
        model(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, e, r, l, nw);
        run_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hDEADBEEF || obs_lat !== 5) begin
            n_fail++; $display("FAIL t1_load: got rdata=%h lat=%0d expected DEADBEEF lat=5", obs_rdata, obs_lat);
        end
    endtask

    task automatic test_byte_half();
        logic e; logic [31:0] r; int l, nw;
        run_req(1'b0, 1'b1, 2'b00, 32'h13, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hFFFFFFDE || obs_lat !== 2) begin
            n_fail++; $display("FAIL t2_byte_signed: got %h lat=%0d expected FFFFFFDE lat=2", obs_rdata, obs_lat);
        end
        run_req(1'b0, 1'b0, 2'b00, 32'h13, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'h000000DE) begin
            n_fail++; $display("FAIL t2_byte_unsigned: got %h expected 000000DE", obs_rdata);
        end
        run_req(1'b0, 1'b1, 2'b01, 32'h12, 32'h0);
        n_checks++;
        if (obs_rdata !== 32'hFFFFDEAD || obs_lat !== 3) begin
            n_fail++; $display("FAIL t3_half_signed: got %h lat=%0d expected FFFFDEAD lat=3", obs_rdata, obs_lat);
        end
        model(1'b1, 1'b0, 2'b01, 32'h11, 32'hFFFF, e, r, l, nw);
        run_req(1'b1, 1'b0, 2'b01, 32'h11, 32'hFFFF);
        n_checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_lat !== 1 || obs_wa.size() != 0) begin
            n_fail++; $display("FAIL t3_misaligned: got err=%b rdata=%h lat=%0d writes=%0d expected 1/0/1/0",
                               obs_err, obs_rdata, obs_lat, obs_wa.size());
        end
    endtask

    task automatic test_range();
        logic e; logic [31:0] r; int l, nw;
        model(1'b1, 1'b0, 2'b10, 32'hFC, 32'h04030201, e, r, l, nw);
        run_req(1'b1, 1'b0, 2'b10, 32'hFC, 32'h04030201);
        n_checks++;
        if (obs_wa.size() !== 4 || obs_wa[0] !== 8'hFC || obs_wa[3] !== 8'hFF || obs_wd[3] !== 8'h04) begin
            n_fail++; $display("FAIL t4_top_word: got %0d writes first=%h last=%h expected 4 FC..FF",
                               obs_wa.size(), obs_wa[0], obs_wa[obs_wa.size()-1]);
        end
        run_req(1'b1, 1'b0, 2'b10, 32'h100, 32'h12345678);
        n_checks++;
        if (obs_err !== 1'b1 || obs_wa.size() != 0 || obs_lat !== 1) begin
            n_fail++; $display("FAIL t4_out_of_range: got err=%b writes=%0d lat=%0d expected 1/0/1",
                               obs_err, obs_wa.size(), obs_lat);
        end
        model(1'b1, 1'b0, 2'b01, 32'hFE, 32'h0000A55A, e, r, l, nw);
        run_req(1'b1, 1'b0, 2'b01, 32'hFE, 32'h0000A55A);
        n_checks++;
        if (obs_wa.size() !== 2 || {obs_wa[0], obs_wa[1], obs_wd[0], obs_wd[1]} !== 32'hFEFF5AA5) begin
            n_fail++; $display("FAIL t4_top_half: got %0d writes at %h expected FE,FF data 5A,A5",
                               obs_wa.size(), obs_wa[0]);
        end
    endtask

    task automatic test_reset_midop();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_sign = 1'b0; req_size = 2'b10;
        req_addr = 32'h40; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h41) begin
            n_fail++; $display("FAIL t5_second_cycle: got we=%b addr=%h expected 1/41", mem_we, mem_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL t5_we_drop: got %b expected 0", mem_we); end
        @(negedge clk);
        rst = 1'b0;
        ref_mem[8'h40] = 8'h44;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL t5_abandon: got rsp_seen=%b ready=%b expected 0/1", seen, req_ready);
        end
        n_checks++;
        if ({tb_mem[8'h40], tb_mem[8'h41], tb_mem[8'h42], tb_mem[8'h43]} !==
            {ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]}) begin
            n_fail++; $display("FAIL t5_mem: got %h %h %h %h expected %h %h %h %h",
                               tb_mem[8'h40], tb_mem[8'h41], tb_mem[8'h42], tb_mem[8'h43],
                               ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]);
        end
    endtask

    task automatic test_back_to_back();
        int acc, pulses;
        logic [31:0] expq[$];
        logic [31:0] exp_v;
        acc = 0; pulses = 0;
        @(negedge clk);
        req_we = 1'b0; req_sign = 1'b0; req_size = 2'b00; req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                exp_v = (expq.size() > 0) ? expq.pop_front() : 32'hx;
                n_checks++;
                if (rsp_rdata !== exp_v) begin
                    n_fail++; $display("FAIL t6_rdata: pulse %0d got %h expected %h", pulses, rsp_rdata, exp_v);
                end
            end
            if (req_ready) begin
                if (acc == 3) req_valid = 1'b0;
                else begin
                    req_addr = 32'h20 + acc;
                    expq.push_back({24'd0, ref_mem[8'h20 + acc]});
                    acc++;
                end
            end
        end
        n_checks++;
        if (pulses !== 3) begin n_fail++; $display("FAIL t6_pulses: got %0d expected 3", pulses); end
    endtask

    task automatic test_random();
        logic we, sign, e;
        logic [1:0] size;
        logic [31:0] addr, wdata, r;
        int l, nw, bad;
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom); sign = 1'($urandom); wdata = $urandom;
            l = $urandom_range(0, 9);
            size = (l < 3) ? 2'b00 : (l < 6) ? 2'b01 : (l < 9) ? 2'b10 : 2'b11;
            addr = $urandom_range(0, MSIZE - 1);
            if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom << ADDR_W) | 32'h100;
            model(we, sign, size, addr, wdata, e, r, l, nw);
            run_req(we, sign, size, addr, wdata);
            n_checks++;
            if (obs_err !== e || obs_rdata !== r || obs_lat !== l) begin
                n_fail++; $display("FAIL rnd_rsp[%0d]: we=%b sz=%0d a=%h got err=%b rd=%h lat=%0d expected %b %h %0d",
                                   t, we, size, addr, obs_err, obs_rdata, obs_lat, e, r, l);
            end
            n_checks++;
            if (obs_wa.size() !== nw || !obs_busy_ok || obs_after) begin
                n_fail++; $display("FAIL rnd_proto[%0d]: got writes=%0d busy_ok=%b extra_rsp=%b expected %0d/1/0",
                                   t, obs_wa.size(), obs_busy_ok, obs_after, nw);
            end else begin
                for (int i = 0; i < nw; i++) begin
                    n_checks++;
                    if (obs_wa[i] !== 8'((addr + i) % MSIZE) || obs_wd[i] !== wdata[8*i +: 8]) begin
                        n_fail++; $display("FAIL rnd_write[%0d.%0d]: got %h<=%h expected %h<=%h",
                                           t, i, obs_wa[i], obs_wd[i], 8'((addr + i) % MSIZE), wdata[8*i +: 8]);
                    end
                end
            end
        end
        bad = 0;
        for (int i = 0; i < MSIZE; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rnd_mem_image: got %0d differing bytes expected 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_sign = 1'b0; req_size = 2'b00;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_word();
        test_byte_half();
        test_range();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
